mem_seq: RTL and testbench

//  Parametrised multi-byte memory access sequencer. It moves a DW-bit word to or from a byte-wide synchronous RAM as 1..NB consecutive little-endian byte accesses.
//  It is the next generation of the fixed 64-bit loader/reader pair behind the CPU control FSM.

---
 rtl/mem_seq_if.sv | 50 +++++
 rtl/mem_seq.sv | 171 +++++++++++++++++
 tb/tb_mem_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_if.sv
// ============================================================================
// Module : mem_seq_if
// Brief  : Request/response and byte-RAM bus bundle for mem_seq.
//          MEM_SEQ_SEXT_EN adds the sext request bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_seq_if #(
  parameter int DW = 64,
  parameter int AW = 16,
  parameter int SW = 4
);
  logic          start;
  logic          wr;
  logic [SW-1:0] size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
`ifdef MEM_SEQ_SEXT_EN
  logic          sext;
`endif
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  // Environment side: requester plus the byte RAM.
  modport master (
`ifdef MEM_SEQ_SEXT_EN
    output sext,
`endif
    output start, wr, size, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_we, mem_wdata
  );

  // Sequencer side.
  modport slave (
`ifdef MEM_SEQ_SEXT_EN
    input  sext,
`endif
    input  start, wr, size, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_seq.sv
// ============================================================================
// Module : mem_seq
// Brief  : Moves a DW-bit word to/from a byte-wide sync RAM as 1..NB
//          little-endian byte accesses. Optional macro: MEM_SEQ_SEXT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_seq #(
  parameter int DW = 64,
  parameter int AW = 16,
  parameter int SW = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  mem_seq_if.slave  bus
);

  localparam int c_NB = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic          wr_q;
  logic [SW-1:0] size_q;
  logic [SW-1:0] k_q;
  logic [SW-1:0] cap_k_q;
  logic          cap_vld_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] buf_q;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [7:0]    mem_wdata_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
`ifdef MEM_SEQ_SEXT_EN
  logic          sext_q;
`endif

  logic          w_size_ok;
  logic [DW-1:0] buf_d;
  logic [DW-1:0] rdata_d;
  logic [7:0]    w_fill;

  assign w_size_ok = (bus.size != '0) && (bus.size <= SW'(c_NB));

  // The RAM returns the byte one cycle after its address, so capture lags k by one.
  always_comb begin
    buf_d = buf_q;
    if (cap_vld_q) begin
      buf_d[{cap_k_q, 3'b000} +: 8] = bus.mem_rdata;
    end
  end

  always_comb begin
    w_fill = 8'h00;
`ifdef MEM_SEQ_SEXT_EN
    if (sext_q && buf_d[{size_q - SW'(1), 3'b111}]) begin
      w_fill = 8'hFF;
    end
`endif
    rdata_d = buf_d;
    for (int i = 0; i < c_NB; i++) begin
      if (i >= int'(size_q)) begin
        rdata_d[i*8 +: 8] = w_fill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      size_q      <= '0;
      k_q         <= '0;
      cap_k_q     <= '0;
      cap_vld_q   <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_SEQ_SEXT_EN
      sext_q      <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cap_vld_q <= (state_q == S_ACC) && !wr_q;
      cap_k_q   <= k_q;
      buf_q     <= buf_d;

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (w_size_ok) begin
              state_q     <= S_ACC;
              busy_q      <= 1'b1;
              wr_q        <= bus.wr;
              size_q      <= bus.size;
              k_q         <= '0;
              mem_addr_q  <= bus.addr;
              mem_we_q    <= bus.wr;
              mem_wdata_q <= bus.wdata[7:0];
              wdata_q     <= bus.wdata >> 8;
`ifdef MEM_SEQ_SEXT_EN
              sext_q      <= bus.sext;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_ACC: begin
          if (k_q == size_q - SW'(1)) begin
            mem_we_q <= 1'b0;
            if (wr_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_TAIL;
            end
          end else begin
            k_q         <= k_q + SW'(1);
            mem_addr_q  <= mem_addr_q + AW'(1);
            mem_wdata_q <= wdata_q[7:0];
            wdata_q     <= wdata_q >> 8;
          end
        end

        S_TAIL: begin
          rdata_q <= rdata_d;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_seq.sv
// ============================================================================
// Module : tb_mem_seq
// Brief  : Directed vector bench for mem_seq with a behavioural sync byte RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_seq;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int SW = 4;

  typedef struct {
    logic          wr;
    logic [SW-1:0] size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          sext;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [DW-1:0] hold_rdata;
  logic [7:0]    ram [0:65535];
  vec_t          vecs [0:13];

  mem_seq_if #(.DW(DW), .AW(AW), .SW(SW)) bus ();

  mem_seq #(.DW(DW), .AW(AW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.start = 1'b1;
    bus.wr    = v.wr;
    bus.size  = v.size;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
`ifdef MEM_SEQ_SEXT_EN
    bus.sext  = v.sext;
`endif
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int            done_cnt, done_cyc, we_cnt, err_cnt, err_cyc;
    logic          busy1, busy_after, addr_ok;
    logic [DW-1:0] rd_at_done;
    logic [AW-1:0] ea;
    done_cnt = 0; done_cyc = 0; we_cnt = 0; err_cnt = 0; err_cyc = 0;
    busy1 = 1'b0; busy_after = 1'b1; addr_ok = 1'b1; rd_at_done = '0;
    @(negedge clk);
    drive(v);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (bus.done) begin done_cnt++; done_cyc = n; rd_at_done = bus.rdata; end
      if (bus.err)  begin err_cnt++;  err_cyc = n; end
      if (bus.mem_we) we_cnt++;
      if (n == 1) busy1 = bus.busy;
      if (n == v.exp_lat + 1) busy_after = bus.busy;
      if (!v.exp_err && n <= int'(v.size)) begin
        ea = v.addr + AW'(n - 1);
        if (bus.mem_addr !== ea) addr_ok = 1'b0;
      end
    end
    if (v.exp_err) begin
      chk({nm, "_err"}, {err_cnt[7:0], err_cyc[7:0]}, {8'd1, 8'd1});
      chk({nm, "_busy"}, busy1, 1'b0);
      chk({nm, "_we"}, we_cnt, 0);
      chk({nm, "_nodone"}, done_cnt, 0);
      chk({nm, "_rdata"}, bus.rdata, hold_rdata);
    end else begin
      chk({nm, "_done"}, {done_cnt[7:0], done_cyc[7:0]}, {8'd1, 8'(v.exp_lat)});
      chk({nm, "_busy"}, {busy1, busy_after}, 2'b10);
      chk({nm, "_we"}, we_cnt, v.wr ? int'(v.size) : 0);
      chk({nm, "_addr"}, addr_ok, 1'b1);
      if (!v.wr) hold_rdata = v.exp_rdata;
      chk({nm, "_rdata"}, rd_at_done, hold_rdata);
    end
  endtask

  initial begin
    int   we_cnt;
    logic addr_ok;
    vec_t v;
    n_tests = 0; n_fail = 0; hold_rdata = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.wr = 1'b0; bus.size = '0; bus.addr = '0; bus.wdata = '0;
`ifdef MEM_SEQ_SEXT_EN
    bus.sext = 1'b0;
`endif

    //            wr    size  addr      wdata                  sext  err   exp_rdata              lat
    vecs[0]  = '{1'b1, 4'd8, 16'h0010, 64'h0807060504030201, 1'b0, 1'b0, 64'h0,                 9};
    vecs[1]  = '{1'b0, 4'd8, 16'h0010, 64'h0,                1'b0, 1'b0, 64'h0807060504030201, 10};
    vecs[2]  = '{1'b1, 4'd2, 16'hFFFF, 64'h55AA,             1'b0, 1'b0, 64'h0,                 3};
    vecs[3]  = '{1'b0, 4'd2, 16'hFFFF, 64'h0,                1'b0, 1'b0, 64'h55AA,              4};
    vecs[4]  = '{1'b0, 4'd0, 16'h0010, 64'h0,                1'b0, 1'b1, 64'h0,                 0};
    vecs[5]  = '{1'b1, 4'd9, 16'h0010, 64'hDEAD,             1'b0, 1'b1, 64'h0,                 0};
    vecs[6]  = '{1'b1, 4'd1, 16'h0020, 64'h80,               1'b0, 1'b0, 64'h0,                 2};
    vecs[7]  = '{1'b0, 4'd1, 16'h0020, 64'h0,                1'b0, 1'b0, 64'h80,                3};
    vecs[8]  = '{1'b0, 4'd3, 16'h0012, 64'h0,                1'b0, 1'b0, 64'h050403,            5};
    vecs[9]  = '{1'b1, 4'd4, 16'h0030, 64'hFFFFFFFFCAFEF00D, 1'b0, 1'b0, 64'h0,                 5};
    vecs[10] = '{1'b0, 4'd4, 16'h0030, 64'h0,                1'b0, 1'b0, 64'hCAFEF00D,          6};
`ifdef MEM_SEQ_SEXT_EN
    vecs[11] = '{1'b0, 4'd1, 16'h0020, 64'h0,                1'b1, 1'b0, 64'hFFFFFFFFFFFFFF80, 3};
`else
    vecs[11] = '{1'b0, 4'd1, 16'h0020, 64'h0,                1'b1, 1'b0, 64'h80,                3};
`endif
    vecs[12] = '{1'b1, 4'd15, 16'h0040, 64'h0,               1'b0, 1'b1, 64'h0,                 0};
    vecs[13] = '{1'b1, 4'd8, 16'h0040, 64'h0,                1'b0, 1'b0, 64'h0,                 9};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("reset_outputs",
        {bus.busy, bus.done, bus.err, bus.mem_we, bus.rdata, bus.mem_addr, bus.mem_wdata},
        '0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i], $sformatf("v%0d", i));
    end

    // start during the DONE cycle must be dropped
    v = '{1'b1, 4'd1, 16'h0050, 64'h11, 1'b0, 1'b0, 64'h0, 2};
    @(negedge clk); drive(v);
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    chk("done_start_done", bus.done, 1'b1);
    @(negedge clk); drive(vecs[7]);
    @(posedge clk); #1; bus.start = 1'b0;
    chk("done_start_ignored", {bus.busy, bus.done, bus.mem_we}, 3'b000);
    @(posedge clk); #1;
    chk("done_start_idle", {bus.busy, bus.mem_we}, 2'b00);

    // starts while busy are ignored, then reset lands on the 3rd ACC cycle
    v = '{1'b1, 4'd8, 16'h0040, 64'hA8A7A6A5A4A3A2A1, 1'b0, 1'b0, 64'h0, 9};
    we_cnt = 0; addr_ok = 1'b1;
    @(negedge clk); drive(v);
    @(posedge clk); #1; bus.start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      if (bus.mem_we) we_cnt++;
      if (bus.mem_addr !== 16'h0040 + 16'(n - 1)) addr_ok = 1'b0;
      @(negedge clk);
      if (n < 3) begin
        drive('{1'b1, 4'd1, 16'h0090, 64'hEE, 1'b0, 1'b0, 64'h0, 0});
      end else begin
        rst = 1'b1;
      end
      @(posedge clk); #1; bus.start = 1'b0;
    end
    chk("rst_we_cycles", we_cnt, 3);
    chk("busy_start_addr", addr_ok, 1'b1);
    chk("rst_mid_outputs",
        {bus.busy, bus.done, bus.err, bus.mem_we, bus.rdata, bus.mem_addr, bus.mem_wdata},
        '0);
    @(negedge clk); rst = 1'b0;
    hold_rdata = '0;
    we_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy || bus.mem_we) we_cnt++;
    end
    chk("rst_mid_quiet", we_cnt, 0);
    v = '{1'b0, 4'd8, 16'h0040, 64'h0, 1'b0, 1'b0, 64'h0000000000A3A2A1, 10};
    run_op(v, "rst_readback");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
